// File: rtl/clock_core.sv
// clock_core: BCD time-of-day clock with runtime 12/24-hour display, two-button time set,
// a blinking field while setting, and a registered multiplexed 7-segment driver.
// Build option: define SECONDS_DISP_EN to show seconds on digits 0-1 (NDIG=6).
// Without it NDIG=4 and seconds are counted but not displayed.
module clock_core #(
    parameter int TICK_DIV        = 27000000,
    parameter int MUX_DIV         = 27000,
    parameter int BLINK_DIV       = 6750000,
    parameter bit SEL_ACTIVE_HIGH = 1'b1,
`ifdef SECONDS_DISP_EN
    localparam int NDIG = 6
`else
    localparam int NDIG = 4
`endif
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            btn_set,
    input  logic            btn_inc,
    input  logic            mode_12h,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] seg_sel,
    output logic            pm,
    output logic            setting
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int MW = MUX_DIV > 1 ? $clog2(MUX_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int DW = $clog2(NDIG);

    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [7:0]      hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
    logic [MW-1:0]   mux_q, mux_d;
    logic [DW-1:0]   dig_q, dig_d;
    logic [BW-1:0]   blink_q, blink_d;
    logic            ph_q, ph_d;
    logic [6:0]      seg_q, seg_d;
    logic [NDIG-1:0] sel_q, sel_d;
    logic            pm_q, pm_d, setting_q, setting_d;
    logic            tick, inc_ok, force_ph, blink_wrap, mux_wrap;
    logic [4:0]      hh_bin, h12;
    logic [3:0]      h_t, h_u, code;
    logic [3:0]      digs [6];
    logic [2:0]      idx;

    // Two-digit BCD increment that wraps to 00 after max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) return 8'h00;
        return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    // 7-segment pattern, bit0=a .. bit6=g; codes above 9 render blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Set FSM next state plus timekeeping; btn_set always beats btn_inc.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        tick    = state_q == RUN && tick_q == TW'(TICK_DIV - 1);
        inc_ok  = btn_inc && !btn_set && state_q != RUN;
        case (state_q)
            RUN: begin
                tick_d = tick ? '0 : tick_q + 1'b1;
                if (tick) begin
                    ss_d = bcd_inc(ss_q, 8'h59);
                    if (ss_q == 8'h59) begin
                        mm_d = bcd_inc(mm_q, 8'h59);
                        if (mm_q == 8'h59) hh_d = bcd_inc(hh_q, 8'h23);
                    end
                end
                if (btn_set) state_d = SET_HR;
            end
            SET_HR: begin
                tick_d = '0;
                if (btn_set) state_d = SET_MIN;
                else if (btn_inc) hh_d = bcd_inc(hh_q, 8'h23);
            end
            SET_MIN: begin
                tick_d = '0;
                if (btn_set) begin
                    state_d = RUN;
                    ss_d    = 8'h00;
                end else if (btn_inc) begin
                    mm_d = bcd_inc(mm_q, 8'h59);
                end
            end
            default: state_d = RUN;
        endcase
        pm_d      = hh_d >= 8'h12;
        setting_d = state_d != RUN;
    end

    // Digit-slot and blink-phase counters; entering a set state or an accepted increment restarts the visible phase.
    always_comb begin
        mux_wrap   = mux_q == MW'(MUX_DIV - 1);
        mux_d      = mux_wrap ? '0 : mux_q + 1'b1;
        dig_d      = !mux_wrap ? dig_q : (dig_q == DW'(NDIG - 1) ? '0 : dig_q + 1'b1);
        force_ph   = (state_d != state_q && state_d != RUN) || inc_ok;
        blink_wrap = blink_q == BW'(BLINK_DIV - 1);
        blink_d    = (force_ph || blink_wrap) ? '0 : blink_q + 1'b1;
        ph_d       = force_ph ? 1'b1 : (blink_wrap ? !ph_q : ph_q);
    end

    // Select and decode the current digit; 12-hour mapping and blink blanking happen here.
    always_comb begin
        hh_bin  = 5'(hh_q[7:4]) * 5'd10 + 5'(hh_q[3:0]);
        h12     = hh_bin == 5'd0 ? 5'd12 : (hh_bin > 5'd12 ? hh_bin - 5'd12 : hh_bin);
        h_t     = !mode_12h ? hh_q[7:4] : (h12 >= 5'd10 ? 4'd1 : 4'hF);
        h_u     = !mode_12h ? hh_q[3:0] : (h12 >= 5'd10 ? 4'(h12 - 5'd10) : h12[3:0]);
        digs[0] = ss_q[3:0];
        digs[1] = ss_q[7:4];
        digs[2] = (state_q == SET_MIN && !ph_q) ? 4'hF : mm_q[3:0];
        digs[3] = (state_q == SET_MIN && !ph_q) ? 4'hF : mm_q[7:4];
        digs[4] = (state_q == SET_HR && !ph_q) ? 4'hF : h_u;
        digs[5] = (state_q == SET_HR && !ph_q) ? 4'hF : h_t;
        idx     = 3'(dig_q) + 3'(6 - NDIG);
        code    = digs[idx];
        seg_d   = seg7(code);
        sel_d   = (NDIG'(1) << dig_q) ^ {NDIG{!SEL_ACTIVE_HIGH}};
    end

    // All state and registered outputs; async reset shows a dash on every digit at 00:00:00.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= RUN;
            tick_q    <= '0;
            hh_q      <= 8'h00;
            mm_q      <= 8'h00;
            ss_q      <= 8'h00;
            mux_q     <= '0;
            dig_q     <= '0;
            blink_q   <= '0;
            ph_q      <= 1'b1;
            seg_q     <= 7'b1000000;
            sel_q     <= {NDIG{SEL_ACTIVE_HIGH}};
            pm_q      <= 1'b0;
            setting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            hh_q      <= hh_d;
            mm_q      <= mm_d;
            ss_q      <= ss_d;
            mux_q     <= mux_d;
            dig_q     <= dig_d;
            blink_q   <= blink_d;
            ph_q      <= ph_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
            pm_q      <= pm_d;
            setting_q <= setting_d;
        end
    end

    assign seg     = seg_q;
    assign seg_sel = sel_q;
    assign pm      = pm_q;
    assign setting = setting_q;
endmodule

// File: tb/tb_clock_core.sv
// tb_clock_core: scoreboard bench for clock_core with TICK_DIV=10, MUX_DIV=4, BLINK_DIV=20.
module tb_clock_core;
`ifdef SECONDS_DISP_EN
    localparam int NDIG = 6;
`else
    localparam int NDIG = 4;
`endif
    localparam int TICK  = 10;
    localparam int MUX   = 4;
    localparam int BLINK = 20;

    logic            sys_clk   = 1'b0;
    logic            sys_rst_n = 1'b1;
    logic            btn_set   = 1'b0;
    logic            btn_inc   = 1'b0;
    logic            mode_12h  = 1'b0;
    logic [6:0]      seg;
    logic [NDIG-1:0] seg_sel;
    logic            pm, setting;
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;

    typedef struct packed {
        logic            chk;
        logic [NDIG-1:0] sel;
        logic [6:0]      seg;
    } exp_t;
    exp_t sb[$];

    clock_core #(.TICK_DIV(TICK), .MUX_DIV(MUX), .BLINK_DIV(BLINK), .SEL_ACTIVE_HIGH(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .btn_set(btn_set), .btn_inc(btn_inc),
        .mode_12h(mode_12h), .seg(seg), .seg_sel(seg_sel), .pm(pm), .setting(setting)
    );

    always #5 sys_clk = ~sys_clk;

    // Rising edges since the last reset release; drives the display model.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Queue the expected seg/seg_sel for the next n cycles with a static hh:mm display.
    task automatic push_static(input int ht, input int hu, input int mt, input int mu, input int n);
        exp_t x;
        int   c, i, p;
        for (int k = 1; k <= n; k++) begin
            c     = cyc + k;
            i     = ((c - 1) / MUX) % NDIG;
            p     = i - (NDIG - 4);
            x.chk = p >= 0;
            x.sel = NDIG'(1) << i;
            x.seg = seg_of(p == 0 ? mu : p == 1 ? mt : p == 2 ? hu : ht);
            sb.push_back(x);
        end
    endtask

    task automatic pulse(input logic s, input logic i);
        btn_set = s;
        btn_inc = i;
        @(negedge sys_clk);
        btn_set = 1'b0;
        btn_inc = 1'b0;
    endtask

    task automatic apply_reset;
        #2 sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        exp_t x;
        #3 sys_rst_n = 1'b0;
        #1;
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, 7'b1000000); end
        checks++; if (seg_sel !== {NDIG{1'b1}}) begin errors++; $display("FAIL reset_sel: got %b expected all ones", seg_sel); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm: got %b expected 0", pm); end
        checks++; if (setting !== 1'b0) begin errors++; $display("FAIL reset_setting: got %b expected 0", setting); end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        push_static(0, 0, 0, 0, 2 * NDIG * MUX);
        while (sb.size() > 0) begin
            @(negedge sys_clk);
            x = sb.pop_front();
            checks++;
            if (seg_sel !== x.sel || (x.chk && seg !== x.seg)) begin
                errors++;
                $display("FAIL reset_disp: seg_sel=%b seg=%b expected seg_sel=%b seg=%b", seg_sel, seg, x.sel, x.seg);
            end
        end
    endtask

    task automatic test_run;
        exp_t x;
        repeat (600 * TICK - cyc) @(negedge sys_clk);
        checks++; if (dut.ss_q !== 8'h00) begin errors++; $display("FAIL run_ss: got %h expected 00", dut.ss_q); end
        checks++; if (dut.mm_q !== 8'h10) begin errors++; $display("FAIL run_mm: got %h expected 10", dut.mm_q); end
        checks++; if (dut.hh_q !== 8'h00) begin errors++; $display("FAIL run_hh: got %h expected 00", dut.hh_q); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL run_pm: got %b expected 0", pm); end
        push_static(0, 0, 1, 0, 2 * NDIG * MUX);
        while (sb.size() > 0) begin
            @(negedge sys_clk);
            x = sb.pop_front();
            checks++;
            if (seg_sel !== x.sel || (x.chk && seg !== x.seg)) begin
                errors++;
                $display("FAIL run_disp: seg_sel=%b seg=%b expected seg_sel=%b seg=%b", seg_sel, seg, x.sel, x.seg);
            end
        end
    endtask

    task automatic test_rollover;
        exp_t x;
        apply_reset;
        pulse(1, 0);
        repeat (23) pulse(0, 1);
        pulse(1, 0);
        repeat (59) pulse(0, 1);
        pulse(1, 0);
        repeat (59 * TICK) @(negedge sys_clk);
        checks++; if ({dut.hh_q, dut.mm_q, dut.ss_q} !== 24'h235959) begin errors++; $display("FAIL roll_pre: got %h expected 235959", {dut.hh_q, dut.mm_q, dut.ss_q}); end
        repeat (TICK - 1) @(negedge sys_clk);
        checks++; if (pm !== 1'b1 || dut.hh_q !== 8'h23) begin errors++; $display("FAIL roll_edge_before: pm=%b hh=%h expected pm=1 hh=23", pm, dut.hh_q); end
        @(negedge sys_clk);
        checks++; if ({dut.hh_q, dut.mm_q, dut.ss_q} !== 24'h000000) begin errors++; $display("FAIL roll_wrap: got %h expected 000000", {dut.hh_q, dut.mm_q, dut.ss_q}); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL roll_pm: got %b expected 0", pm); end
        push_static(0, 0, 0, 0, 2 * NDIG * MUX);
        while (sb.size() > 0) begin
            @(negedge sys_clk);
            x = sb.pop_front();
            checks++;
            if (seg_sel !== x.sel || (x.chk && seg !== x.seg)) begin
                errors++;
                $display("FAIL roll_disp: seg_sel=%b seg=%b expected seg_sel=%b seg=%b", seg_sel, seg, x.sel, x.seg);
            end
        end
    endtask

    task automatic test_12h;
        exp_t x;
        apply_reset;
        mode_12h = 1'b1;
        push_static(1, 2, 0, 0, 2 * NDIG * MUX);
        while (sb.size() > 0) begin
            @(negedge sys_clk);
            x = sb.pop_front();
            checks++;
            if (seg_sel !== x.sel || (x.chk && seg !== x.seg)) begin
                errors++;
                $display("FAIL h12_midnight: seg_sel=%b seg=%b expected seg_sel=%b seg=%b", seg_sel, seg, x.sel, x.seg);
            end
        end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL h12_pm0: got %b expected 0", pm); end
        pulse(1, 0);
        repeat (13) pulse(0, 1);
        pulse(1, 0);
        pulse(1, 0);
        push_static(15, 1, 0, 0, 2 * NDIG * MUX);
        while (sb.size() > 0) begin
            @(negedge sys_clk);
            x = sb.pop_front();
            checks++;
            if (seg_sel !== x.sel || (x.chk && seg !== x.seg)) begin
                errors++;
                $display("FAIL h12_one_pm: seg_sel=%b seg=%b expected seg_sel=%b seg=%b", seg_sel, seg, x.sel, x.seg);
            end
        end
        checks++; if (pm !== 1'b1) begin errors++; $display("FAIL h12_pm1: got %b expected 1", pm); end
        mode_12h = 1'b0;
    endtask

    task automatic test_set_fields;
        apply_reset;
        repeat (25 * TICK) @(negedge sys_clk);
        pulse(1, 0);
        repeat (25) pulse(0, 1);
        checks++; if ({dut.hh_q, dut.mm_q, dut.ss_q} !== 24'h010025) begin errors++; $display("FAIL set_hr: got %h expected 010025", {dut.hh_q, dut.mm_q, dut.ss_q}); end
        checks++; if (setting !== 1'b1) begin errors++; $display("FAIL set_hr_setting: got %b expected 1", setting); end
        pulse(1, 0);
        repeat (61) pulse(0, 1);
        pulse(1, 0);
        checks++; if ({dut.hh_q, dut.mm_q, dut.ss_q} !== 24'h010100) begin errors++; $display("FAIL set_min: got %h expected 010100", {dut.hh_q, dut.mm_q, dut.ss_q}); end
        checks++; if (setting !== 1'b0) begin errors++; $display("FAIL set_exit_setting: got %b expected 0", setting); end
    endtask

    task automatic test_back_to_back;
        exp_t x;
        int   k, i, p;
        logic ph;
        apply_reset;
        pulse(1, 1);
        k = cyc;
        checks++; if (setting !== 1'b1) begin errors++; $display("FAIL b2b_setting: got %b expected 1", setting); end
        checks++; if (dut.hh_q !== 8'h00) begin errors++; $display("FAIL b2b_hh: got %h expected 00", dut.hh_q); end
        for (int c = k + 1; c <= k + 4 * BLINK; c++) begin
            i     = ((c - 1) / MUX) % NDIG;
            p     = i - (NDIG - 4);
            ph    = (((c - 1 - k) / BLINK) % 2) == 0;
            x.chk = p >= 0;
            x.sel = NDIG'(1) << i;
            x.seg = (p >= 2 && !ph) ? 7'h00 : seg_of(0);
            sb.push_back(x);
        end
        while (sb.size() > 0) begin
            @(negedge sys_clk);
            x = sb.pop_front();
            checks++;
            if (seg_sel !== x.sel || (x.chk && seg !== x.seg)) begin
                errors++;
                $display("FAIL b2b_blink: cycle=%0d seg_sel=%b seg=%b expected seg_sel=%b seg=%b", cyc, seg_sel, seg, x.sel, x.seg);
            end
        end
    endtask

    task automatic test_reset_mid_set;
        apply_reset;
        pulse(1, 0);
        repeat (15) pulse(0, 1);
        pulse(1, 0);
        repeat (3) pulse(0, 1);
        checks++; if (pm !== 1'b1 || setting !== 1'b1) begin errors++; $display("FAIL mid_pre: pm=%b setting=%b expected 1 1", pm, setting); end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++; if (seg !== 7'b1000000) begin errors++; $display("FAIL mid_seg: got %b expected %b", seg, 7'b1000000); end
        checks++; if (seg_sel !== {NDIG{1'b1}}) begin errors++; $display("FAIL mid_sel: got %b expected all ones", seg_sel); end
        checks++; if (pm !== 1'b0 || setting !== 1'b0) begin errors++; $display("FAIL mid_flags: pm=%b setting=%b expected 0 0", pm, setting); end
        checks++; if ({dut.hh_q, dut.mm_q} !== 16'h0000) begin errors++; $display("FAIL mid_time: got %h expected 0000", {dut.hh_q, dut.mm_q}); end
        btn_set = 1'b1;
        @(negedge sys_clk);
        btn_set   = 1'b0;
        sys_rst_n = 1'b1;
        repeat (TICK) @(negedge sys_clk);
        checks++; if (setting !== 1'b0) begin errors++; $display("FAIL mid_lost_pulse: setting=%b expected 0", setting); end
        checks++; if ({dut.hh_q, dut.mm_q, dut.ss_q} !== 24'h000001) begin errors++; $display("FAIL mid_run: got %h expected 000001", {dut.hh_q, dut.mm_q, dut.ss_q}); end
    endtask

    initial begin
        test_reset;
        test_run;
        test_rollover;
        test_12h;
        test_set_fields;
        test_back_to_back;
        test_reset_mid_set;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_core.md
# clock_core

Parametrised successor to the fixed-rate 24-hour digital clock. It provides a BCD time-of-day counter with a runtime 12/24-hour display mode and a two-button time-set state machine. The selected field blinks while it is being set. A registered N-digit multiplexed 7-segment driver sits between the board pins and the clock logic, and replaces the fixed four-digit clock top.

## Interface
- TICK_DIV, 27000000: sys_clk cycles per one-second tick. Must be ≥2.
- MUX_DIV, 27000: sys_clk cycles per digit slot.
- BLINK_DIV, 6750000: sys_clk cycles per blink-phase toggle.
- SEL_ACTIVE_HIGH, 1: polarity of seg_sel. 1 means the enabled digit is driven 1.
- sys_clk  in  1  single clock, all logic on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- btn_set  in  1  one-cycle pulse, already debounced and synchronised. Advances the set FSM.
- btn_inc  in  1  one-cycle pulse, already debounced and synchronised. Increments the field being set.
- mode_12h  in  1  level. 1 selects 12-hour display. Sampled every cycle.
- seg  out  7  segments, bit0=a … bit6=g, active-high.
- seg_sel  out  NDIG  one-hot digit enable. NDIG=6 with SECONDS_DISP_EN, else 4.
- pm  out  1  high when the internal hour ≥12, in either display mode.
- setting  out  1  high in SET_HR or SET_MIN.

## Operation
- Internal time is always 24-hour BCD: hh 00–23, mm 00–59, ss 00–59. Each digit is 4 bits.
- Tick: tick_cnt counts 0..TICK_DIV-1. The tick is asserted on the cycle where tick_cnt==TICK_DIV-1. tick_cnt then wraps to 0.
- RUN state, on each tick:
  - ss increments.
  - 59 wraps to 00 and carries into mm.
  - mm 59 wraps to 00 and carries into hh.
  - 23:59:59 wraps to 00:00:00.
- FSM states: RUN → SET_HR → SET_MIN → RUN. Each btn_set pulse advances one state.
- SET_HR and SET_MIN behaviour:
  - tick_cnt is held at 0. ss is held.
  - btn_inc increments only the active field: hh 23→00, mm 59→00. There is no carry.
- Leaving SET_MIN clears ss to 00 and tick_cnt to 0.
- Simultaneous btn_set and btn_inc: btn_set wins and btn_inc is ignored.
- Tick coincident with btn_set in RUN: the tick increment and the transition to SET_HR both take effect on the same edge.
- Blink: blink_ph toggles every BLINK_DIV cycles.
  - It is forced to 1 on entry to SET_HR or SET_MIN, and on every accepted btn_inc.
  - When blink_ph=0, the digits of the active field show blank (seg=0).
- 12-hour display mapping: hh 00→12, 13–23→01–11. The hours-tens digit is blanked when it is 0.
- 24-hour display: all digits are shown, including leading zeros.
- Digit order, index 0 first: [ss units, ss tens,] mm units, mm tens, hh units, hh tens.
- Digit index advances when mux_cnt==MUX_DIV-1, and wraps from NDIG-1 to 0.
- The decoder covers BCD 0–9. Codes 10–15 show blank.

## Timing
- Reset values:
  - seg=7'b1000000 (dash).
  - seg_sel all enabled.
  - pm=0, setting=0.
  - Time 00:00:00, FSM=RUN.
  - All counters 0, digit index 0, blink_ph=1.
- Counter and FSM updates take effect on the edge of the triggering tick or pulse.
- seg and seg_sel are registered, one cycle after the digit index or time change.
- pm and setting are registered, and change on the same edge as hh or the FSM state.
- Reset asserted mid-operation returns everything to the reset values immediately, because the reset is asynchronous. Pulses during reset are lost.

## Configuration
- SECONDS_DISP_EN defined:
  - NDIG=6; seconds are displayed on digits 0–1.
- SECONDS_DISP_EN undefined:
  - NDIG=4; seconds are counted but not displayed.
- Timekeeping is identical in both builds.

## Test plan
Bench parameters: TICK_DIV=10, MUX_DIV=4, BLINK_DIV=20.
- Reset release, then 600 ticks → time 00:10:00, pm=0. Each digit slot lasts 4 cycles, and seg_sel rotates one-hot.
- Preload 23:59:59 via set mode plus ticks, then one tick → 00:00:00. pm falls on the same edge as hh.
- mode_12h=1 with hh=00, then 13 → hour digits display "12" then " 1". The tens digit is blank (seg=0). pm=0 then 1.
- btn_set, then btn_inc ×25 → hh=01, with mm and ss unchanged. Then btn_set, btn_inc ×61, btn_set → mm=01, ss=00, setting=0.
- btn_set and btn_inc in the same cycle from RUN → state SET_HR, hh unchanged. In SET_HR the hour digits blank for 20 cycles and show for 20 cycles.
- Assert sys_rst_n low mid-SET_MIN → outputs are at reset values asynchronously, and the FSM returns to RUN.
